// File: rtl/spi_mnrch_pkg.sv
// spi_mnrch_pkg
// Shared types and constants for the 16-bit SPI monarch transaction engine.
//   state_e    : transaction FSM states (IDLE, FRONT, SHIFT, BACK)
//   SPI_LEN    : bits per transaction
//   cnt_width  : SCLK divider counter width for a given SCLK_DIV
package spi_mnrch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRONT = 2'd1,
    SHIFT = 2'd2,
    BACK  = 2'd3
  } state_e;

  localparam int SPI_LEN = 16;

  // SCLK_DIV is a power of two, so the divider is exactly log2 bits wide
  // and its MSB is a 50% duty SCLK.
  function automatic int cnt_width(input int div);
    return $clog2(div);
  endfunction

endpackage

// File: rtl/spi_mnrch_xfer.sv
// spi_mnrch_xfer
// 16-bit SPI monarch (mode 3) transaction engine. A one-cycle wrt launches a
// transfer of cmd, shifted out MSB-first on MOSI while MISO is captured on
// SCLK rises. done pulses for one cycle when the 16-bit response is in
// rd_data.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   wrt      in   one-cycle start strobe, cmd sampled in the same cycle
//   cmd      in   [15:0] word to transmit
//   MISO     in   serial data from sensor
//   SS_n     out  active-low slave select
//   SCLK     out  serial clock, idles high (divider counter MSB)
//   MOSI     out  serial data to sensor (shift register MSB)
//   done     out  one-cycle completion pulse
//   rd_data  out  [15:0] received word (shift register contents)
//   cmd_full out  command buffer occupied (only with SPI_MNRCH_XFER_QUEUE_EN)
//
// Build option: define SPI_MNRCH_XFER_QUEUE_EN to add a one-entry command
// buffer that accepts a wrt while busy and launches it right after done.
// Without it, wrt while busy is ignored and cmd_full does not exist.
//
// Parameter SCLK_DIV: clk cycles per SCLK period, power of two, >= 8.
module spi_mnrch_xfer
  import spi_mnrch_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        done,
  output logic [15:0] rd_data
`ifdef SPI_MNRCH_XFER_QUEUE_EN
  ,
  output logic        cmd_full
`endif
);

  localparam int CW = cnt_width(SCLK_DIV);
  localparam int BW = $clog2(SPI_LEN + 1);

  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_HALF  = CW'(SCLK_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_FRONT = CW'(3 * SCLK_DIV / 4 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(SPI_LEN - 1);

  state_e              r_state;
  logic [CW-1:0]       r_cnt;
  logic [BW-1:0]       r_bitcnt;
  logic [SPI_LEN-1:0]  r_shft;
  logic                r_shadow;
  logic                r_ss_n;
  logic                r_done;

  logic                w_launch;
  logic [SPI_LEN-1:0]  w_launch_word;

`ifdef SPI_MNRCH_XFER_QUEUE_EN
  logic                r_full;
  logic [SPI_LEN-1:0]  r_qcmd;

  // A buffered word only exists in IDLE during the done cycle; it takes
  // priority over an external wrt arriving in that same cycle.
  assign w_launch      = r_full | wrt;
  assign w_launch_word = r_full ? r_qcmd : cmd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_qcmd <= '0;
    end else if (r_state == IDLE) begin
      if (r_full) begin
        // Buffered word launches now; a coincident wrt refills the buffer.
        if (wrt) r_qcmd <= cmd;
        else     r_full <= 1'b0;
      end
    end else if (wrt && !r_full) begin
      r_qcmd <= cmd;
      r_full <= 1'b1;
    end
  end

  assign cmd_full = r_full;
`else
  assign w_launch      = wrt;
  assign w_launch_word = cmd;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= CNT_MAX;
      r_bitcnt <= '0;
      r_shft   <= '0;
      r_shadow <= 1'b0;
      r_ss_n   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt  <= CNT_MAX;
          r_ss_n <= 1'b1;
          if (w_launch) begin
            // Start three quarters into a period so SS_n leads the first
            // SCLK fall by a quarter period of setup.
            r_shft   <= w_launch_word;
            r_cnt    <= CNT_FRONT;
            r_ss_n   <= 1'b0;
            r_bitcnt <= '0;
            r_state  <= FRONT;
          end
        end

        FRONT: begin
          // First fall carries no shift: MOSI already holds cmd[15].
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_MAX) r_state <= SHIFT;
        end

        SHIFT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_HALF) begin
            // MISO held in a shadow bit until the following fall so MOSI
            // only ever moves on falling SCLK.
            r_shadow <= MISO;
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == LAST_BIT) r_state <= BACK;
          end
          if (r_cnt == CNT_MAX) r_shft <= {r_shft[SPI_LEN-2:0], r_shadow};
        end

        BACK: begin
          if (r_cnt == CNT_MAX) begin
            // Final shift without a fall: counter held so SCLK stays high.
            r_shft  <= {r_shft[SPI_LEN-2:0], r_shadow};
            r_ss_n  <= 1'b1;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign SS_n    = r_ss_n;
  assign SCLK    = r_cnt[CW-1];
  assign MOSI    = r_shft[SPI_LEN-1];
  assign done    = r_done;
  assign rd_data = r_shft;

endmodule

// File: tb/tb_spi_mnrch_xfer.sv
// Testbench for spi_mnrch_xfer (SCLK_DIV=32). A cycle-level model derived from
// the transfer timeline (offset k from the wrt-sampling edge) predicts the
// pins every cycle; directed cases add literal expectations.
module tb_spi_mnrch_xfer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wrt = 1'b0;
  logic [15:0] cmd = 16'h0;
  wire         MISO;
  logic        SS_n, SCLK, MOSI, done;
  logic [15:0] rd_data;
`ifdef SPI_MNRCH_XFER_QUEUE_EN
  logic        cmd_full;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_mnrch_xfer #(.SCLK_DIV(32)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .cmd     (cmd),
    .MISO    (MISO),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .done    (done),
    .rd_data (rd_data)
`ifdef SPI_MNRCH_XFER_QUEUE_EN
    ,
    .cmd_full(cmd_full)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- sensor model (mode 3 slave) ----------------
  logic        loopback = 1'b1;
  logic [15:0] sens_resp = 16'h0;
  logic        sens_bit = 1'b0;
  logic [15:0] sens_cap = 16'h0;
  int          sens_rises = 0;

  assign MISO = loopback ? MOSI : sens_bit;

  always @(negedge SS_n) begin
    sens_rises = 0;
    sens_cap   = 16'h0;
    sens_bit   = sens_resp[15];
  end
  always @(posedge SCLK) if (SS_n === 1'b0) begin
    sens_cap = {sens_cap[14:0], MOSI};
    sens_rises++;
  end
  always @(negedge SCLK) if (SS_n === 1'b0 && sens_rises < 16) sens_bit = sens_resp[15 - sens_rises];

  // ---------------- behavioural model + per-cycle compare ----------------
  int          cyc = 0;
  int          m_start = -1;
  logic [15:0] m_cmd = 16'h0, m_resp = 16'h0, m_rd = 16'h0;
  logic        m_full = 1'b0;
  logic [15:0] m_qcmd = 16'h0;
  logic        chk_en = 1'b0;
  int          done_cnt = 0;
  int          rises_cnt = 0;
  int          mosi_viol = 0;
  logic        prev_sclk = 1'b1, prev_mosi = 1'b0;

  task automatic m_launch(input logic [15:0] w);
    m_start = cyc;
    m_cmd   = w;
    m_resp  = loopback ? w : sens_resp;
  endtask

  initial forever begin
    int          k;
    logic        idle, busy, e_ss, e_sclk, e_mosi, e_done, e_full, a_full;
    logic [31:0] sr;
    int          j;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_start = -1;
      m_rd    = 16'h0;
      m_full  = 1'b0;
      m_qcmd  = 16'h0;
    end else begin
      idle = (m_start < 0) || (cyc - 1 - m_start >= 521);
`ifdef SPI_MNRCH_XFER_QUEUE_EN
      if (idle && m_full) begin
        m_launch(m_qcmd);
        if (wrt) m_qcmd = cmd;
        else     m_full = 1'b0;
      end else if (idle && wrt) begin
        m_launch(cmd);
      end else if (!idle && wrt && !m_full) begin
        m_qcmd = cmd;
        m_full = 1'b1;
      end
`else
      if (idle && wrt) m_launch(cmd);
`endif
      if (m_start >= 0 && cyc - m_start == 521) m_rd = m_resp;
    end
    #1;
    k      = (m_start >= 0) ? cyc - m_start : 100000;
    busy   = (m_start >= 0) && (k <= 520);
    e_ss   = !busy;
    e_done = (m_start >= 0) && (k == 521);
    e_sclk = 1'b1;
    if (busy && k >= 9) e_sclk = ((k - 9) % 32) >= 16;
    if (busy) begin
      j      = (k < 41) ? 0 : (k - 41) / 32 + 1;
      sr     = {m_cmd, m_resp} << j;
      e_mosi = sr[31];
    end else begin
      e_mosi = m_rd[15];
    end
`ifdef SPI_MNRCH_XFER_QUEUE_EN
    e_full = m_full;
    a_full = cmd_full;
`else
    e_full = 1'b0;
    a_full = 1'b0;
`endif
    if (chk_en) begin
      check("pins{SS_n,SCLK,MOSI,done,cmd_full}",
            {27'd0, SS_n, SCLK, MOSI, done, a_full},
            {27'd0, e_ss, e_sclk, e_mosi, e_done, e_full});
      if (!busy) check("rd_data_model", {16'd0, rd_data}, {16'd0, m_rd});
    end
    if (done === 1'b1) done_cnt++;
    if (SCLK === 1'b1 && prev_sclk === 1'b0 && SS_n === 1'b0) rises_cnt++;
    if (SCLK === 1'b1 && prev_sclk === 1'b1 && SS_n === 1'b0 && MOSI !== prev_mosi) mosi_viol++;
    prev_sclk = SCLK;
    prev_mosi = MOSI;
  end

  // ---------------- stimulus ----------------
  int launch_cyc;

  task automatic pulse_wrt(input logic [15:0] c);
    @(negedge clk);
    wrt = 1'b1;
    cmd = c;
    launch_cyc = cyc;
    @(negedge clk);
    wrt = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int at1, at2, snap, l2;

    // Reset
    rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_pins{SS_n,SCLK,done}", {29'd0, SS_n, SCLK, done}, 32'h6);
    check("reset_rd_data", {16'd0, rd_data}, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Loopback
    loopback  = 1'b1;
    rises_cnt = 0;
    pulse_wrt(16'hA5C3);
    wait_done("loop", 600, at1);
    check("loop_done_latency", at1 - launch_cyc, 32'd522);
    check("loop_rd_data", {16'd0, rd_data}, 32'h0000A5C3);
    check("loop_ss_n_with_done", {31'd0, SS_n}, 32'd1);
    check("loop_sclk_rises", rises_cnt, 32'd16);
    @(negedge clk);
    check("loop_done_one_cycle", {31'd0, done}, 32'd0);
    repeat (4) @(negedge clk);

    // Sensor model
    loopback  = 1'b0;
    sens_resp = 16'h006A;
    mosi_viol = 0;
    pulse_wrt(16'h8F00);
    wait_done("sens", 600, at1);
    check("sens_rd_data", {16'd0, rd_data}, 32'h0000006A);
    check("sens_captured_cmd", {16'd0, sens_cap}, 32'h00008F00);
    check("sens_rises", sens_rises, 32'd16);
    check("sens_mosi_stable_high", mosi_viol, 32'd0);
    repeat (4) @(negedge clk);

    // Back-to-back
    loopback = 1'b1;
    pulse_wrt(16'h1234);
    wait_done("b2b_first", 600, at1);
    check("b2b_first_rd", {16'd0, rd_data}, 32'h00001234);
    check("b2b_ss_high_at_done", {31'd0, SS_n}, 32'd1);
    wrt = 1'b1;
    cmd = 16'h5678;
    l2  = cyc;
    @(negedge clk);
    wrt = 1'b0;
    check("b2b_ss_low_next_cycle", {31'd0, SS_n}, 32'd0);
    wait_done("b2b_second", 600, at2);
    check("b2b_second_latency", at2 - l2, 32'd522);
    check("b2b_second_rd", {16'd0, rd_data}, 32'h00005678);
    repeat (4) @(negedge clk);

    // Reset mid-transfer
    pulse_wrt(16'hBEEF);
    repeat (199) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pins{SS_n,SCLK}", {30'd0, SS_n, SCLK}, 32'h3);
    rst  = 1'b0;
    snap = done_cnt;
    repeat (600) @(negedge clk);
    check("midrst_no_done", done_cnt - snap, 32'd0);

    // Busy wrt
    snap = done_cnt;
    pulse_wrt(16'h0F0F);
    repeat (98) @(negedge clk);
    pulse_wrt(16'hFFFF);
`ifdef SPI_MNRCH_XFER_QUEUE_EN
    check("q_full_set", {31'd0, cmd_full}, 32'd1);
    repeat (98) @(negedge clk);
    pulse_wrt(16'h3C3C);
    check("q_full_still", {31'd0, cmd_full}, 32'd1);
    wait_done("q_first", 600, at1);
    check("q_first_rd", {16'd0, rd_data}, 32'h00000F0F);
    @(negedge clk);
    check("q_full_cleared", {31'd0, cmd_full}, 32'd0);
    check("q_ss_low_after_gap", {31'd0, SS_n}, 32'd0);
    wait_done("q_second", 600, at2);
    check("q_second_latency", at2 - at1, 32'd522);
    check("q_second_rd", {16'd0, rd_data}, 32'h0000FFFF);
    repeat (600) @(negedge clk);
    check("q_done_count", done_cnt - snap, 32'd2);
`else
    wait_done("busy_first", 600, at1);
    check("busy_rd", {16'd0, rd_data}, 32'h00000F0F);
    repeat (600) @(negedge clk);
    check("busy_done_count", done_cnt - snap, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
